sdram_port_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter sharing the single SDRAM controller slave port of dnn_accel_system between m0 (the Nios II data master) and m1 (the DNN accelerator weight/activation fetch master).
- Single-word transfers with round-robin fairness. Supports pipelined reads with up to MAX_PEND outstanding.
- Returning read data is steered to the issuing master through an in-order ID FIFO.

---
 rtl/sdram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter for the shared SDRAM controller slave port.
// Round-robin single-word grants, pipelined reads steered back through an in-order ID FIFO.
module sdram_port_arbiter #(
   parameter int unsigned ADDR_W   = 24,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_PEND = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   output logic                orphan_err
);

   localparam int unsigned PTR_W = $clog2(MAX_PEND);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);

   typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

   state_t             state, state_nxt;
   logic               last_served;
   logic [CNT_W-1:0]   pend_cnt;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic               id_fifo [MAX_PEND];

   logic elig0, elig1, gnt_vld, sel;
   logic mst_read, mst_write;
   logic accept, push, pop, head;

   // Pending count is the registered value only; a same-cycle pop frees nothing.
   always_comb begin
      elig0 = rst_n & (m0_write | (m0_read & (pend_cnt < PEND_MAX)));
      elig1 = rst_n & (m1_write | (m1_read & (pend_cnt < PEND_MAX)));
   end

   // Grant selection and next state; a held grant is never revoked.
   always_comb begin
      state_nxt = state;
      gnt_vld   = 1'b0;
      sel       = 1'b0;
      case (state)
         IDLE: begin
            gnt_vld = elig0 | elig1;
            sel     = (elig0 & elig1) ? ~last_served : elig1;
            if (gnt_vld && s_waitrequest)
               state_nxt = sel ? HOLD1 : HOLD0;
         end
         HOLD0: begin
            gnt_vld = rst_n;
            sel     = 1'b0;
            if (!s_waitrequest)
               state_nxt = IDLE;
         end
         HOLD1: begin
            gnt_vld = rst_n;
            sel     = 1'b1;
            if (!s_waitrequest)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slave drive, handshakes and read-return steering (zero added latency).
   always_comb begin
      mst_read         = sel ? m1_read  : m0_read;
      mst_write        = sel ? m1_write : m0_write;
      s_write          = gnt_vld & mst_write;
      s_read           = gnt_vld & mst_read & ~mst_write;
      s_address        = sel ? m1_address    : m0_address;
      s_writedata      = sel ? m1_writedata  : m0_writedata;
      s_byteenable     = sel ? m1_byteenable : m0_byteenable;
      accept           = (s_read | s_write) & ~s_waitrequest;
      m0_waitrequest   = ~(gnt_vld & ~sel & ~s_waitrequest);
      m1_waitrequest   = ~(gnt_vld &  sel & ~s_waitrequest);
      push             = accept & s_read;
      pop              = rst_n & s_readdatavalid & (pend_cnt != '0);
      head             = id_fifo[rd_ptr];
      m0_readdatavalid = pop & ~head;
      m1_readdatavalid = pop &  head;
      m0_readdata      = s_readdata;
      m1_readdata      = s_readdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_served <= 1'b1;
         pend_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         orphan_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            last_served <= sel;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         pend_cnt <= pend_cnt + CNT_W'(push) - CNT_W'(pop);
         if (s_readdatavalid && (pend_cnt == '0))
            orphan_err <= 1'b1;
      end
   end

   // ID storage needs no reset; entries are only read behind a nonzero count.
   always_ff @(posedge clk) begin
      if (push)
         id_fifo[wr_ptr] <= sel;
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed vector bench for sdram_port_arbiter: inputs applied after each rising edge,
// combinational and registered outputs compared on the falling edge.
module tb_sdram_port_arbiter;

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam logic [ADDR_W-1:0] A0  = 24'h000A00;
   localparam logic [ADDR_W-1:0] M1A = 24'h000010;
   localparam logic [DATA_W-1:0] WD0 = 16'hA0A0;
   localparam logic [DATA_W-1:0] WD1 = 16'hB1B1;
   localparam logic [BE_W-1:0]   BE0 = 2'b01;
   localparam logic [BE_W-1:0]   BE1 = 2'b10;

   logic clk = 1'b0;
   logic rst_n;
   logic m0_read, m0_write, m1_read, m1_write;
   logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [DATA_W-1:0] m0_readdata, m1_readdata, s_writedata, s_readdata;
   logic [ADDR_W-1:0] s_address;
   logic [BE_W-1:0]   s_byteenable;
   logic s_read, s_write, s_waitrequest, s_readdatavalid, orphan_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(A0), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(WD0), .m0_byteenable(BE0),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(M1A), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(WD1), .m1_byteenable(BE1),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .orphan_err(orphan_err)
   );

   typedef struct {
      logic              rst_n, m0r, m0w, m1r, m1w, swait, srdv;
      logic [DATA_W-1:0] srd;
      logic              e_m0wait, e_m1wait, e_sread, e_swrite;
      logic [ADDR_W-1:0] e_saddr;
      logic              e_m0rdv, e_m1rdv, e_orph;
   } vec_t;

   function automatic vec_t v(input logic r, input logic m0r, input logic m0w,
                              input logic m1r, input logic m1w, input logic sw,
                              input logic srdv, input logic [DATA_W-1:0] srd,
                              input logic e0w, input logic e1w, input logic esr,
                              input logic esw, input logic [ADDR_W-1:0] ea,
                              input logic e0v, input logic e1v, input logic eo);
      vec_t t;
      t.rst_n = r;  t.m0r = m0r; t.m0w = m0w; t.m1r = m1r; t.m1w = m1w;
      t.swait = sw; t.srdv = srdv; t.srd = srd;
      t.e_m0wait = e0w; t.e_m1wait = e1w; t.e_sread = esr; t.e_swrite = esw;
      t.e_saddr = ea; t.e_m0rdv = e0v; t.e_m1rdv = e1v; t.e_orph = eo;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input string tag, input int idx, input vec_t t);
      @(posedge clk);
      #1;
      rst_n = t.rst_n; m0_read = t.m0r; m0_write = t.m0w;
      m1_read = t.m1r; m1_write = t.m1w; s_waitrequest = t.swait;
      s_readdatavalid = t.srdv; s_readdata = t.srd;
      @(negedge clk);
      chk({tag, ".m0_waitrequest"}, idx, 32'(m0_waitrequest), 32'(t.e_m0wait));
      chk({tag, ".m1_waitrequest"}, idx, 32'(m1_waitrequest), 32'(t.e_m1wait));
      chk({tag, ".s_read"}, idx, 32'(s_read), 32'(t.e_sread));
      chk({tag, ".s_write"}, idx, 32'(s_write), 32'(t.e_swrite));
      chk({tag, ".s_address"}, idx, 32'(s_address), 32'(t.e_saddr));
      chk({tag, ".m0_readdatavalid"}, idx, 32'(m0_readdatavalid), 32'(t.e_m0rdv));
      chk({tag, ".m1_readdatavalid"}, idx, 32'(m1_readdatavalid), 32'(t.e_m1rdv));
      chk({tag, ".orphan_err"}, idx, 32'(orphan_err), 32'(t.e_orph));
      chk({tag, ".m0_readdata"}, idx, 32'(m0_readdata), 32'(t.srd));
      chk({tag, ".m1_readdata"}, idx, 32'(m1_readdata), 32'(t.srd));
      if (t.e_swrite) begin
         chk({tag, ".s_writedata"}, idx, 32'(s_writedata),
             32'((t.e_saddr == M1A) ? WD1 : WD0));
         chk({tag, ".s_byteenable"}, idx, 32'(s_byteenable),
             32'((t.e_saddr == M1A) ? BE1 : BE0));
      end
   endtask

   vec_t tbl[$];

   initial begin
      rst_n = 1'b0; m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
      repeat (2) @(posedge clk);

      // reset held with both masters requesting
      tbl.push_back(v(0, 0,1,0,1, 0,0,16'h0,     1,1,0,0, A0,  0,0,0));
      // contention: writes alternate m0,m1 from reset
      for (int i = 0; i < 4; i++) begin
         tbl.push_back(v(1, 0,1,0,1, 0,0,16'h0,  0,1,0,1, A0,  0,0,0));
         tbl.push_back(v(1, 0,1,0,1, 0,0,16'h0,  1,0,0,1, M1A, 0,0,0));
      end
      // hold under stall: m1 granted, 5 stalled cycles while m0 requests
      tbl.push_back(v(1, 0,0,0,1, 1,0,16'h0,     1,1,0,1, M1A, 0,0,0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(1, 0,1,0,1, 1,0,16'h0,  1,1,0,1, M1A, 0,0,0));
      tbl.push_back(v(1, 0,1,0,1, 0,0,16'h0,     1,0,0,1, M1A, 0,0,0));
      tbl.push_back(v(1, 0,1,0,0, 0,0,16'h0,     0,1,0,1, A0,  0,0,0));
      // pending limit: 4 reads accepted, 5th stalls, m0 write still passes
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(1, 0,0,1,0, 0,0,16'h0,  1,0,1,0, M1A, 0,0,0));
      tbl.push_back(v(1, 0,0,1,0, 0,0,16'h0,     1,1,0,0, A0,  0,0,0));
      tbl.push_back(v(1, 0,1,1,0, 0,0,16'h0,     0,1,0,1, A0,  0,0,0));
      tbl.push_back(v(1, 0,0,1,0, 0,1,16'hBEEF,  1,1,0,0, A0,  0,1,0));
      tbl.push_back(v(1, 0,0,1,0, 0,0,16'h0,     1,0,1,0, M1A, 0,0,0));
      for (int i = 1; i <= 4; i++)
         tbl.push_back(v(1, 0,0,0,0, 0,1,16'(i), 1,1,0,0, A0,  0,1,0));
      // interleaved: reads m0,m1,m0 with push+pop on the third
      tbl.push_back(v(1, 1,0,1,0, 0,0,16'h0,     0,1,1,0, A0,  0,0,0));
      tbl.push_back(v(1, 0,0,1,0, 0,0,16'h0,     1,0,1,0, M1A, 0,0,0));
      tbl.push_back(v(1, 1,0,0,0, 0,1,16'h1111,  0,1,1,0, A0,  1,0,0));
      tbl.push_back(v(1, 0,0,0,0, 0,1,16'h2222,  1,1,0,0, A0,  0,1,0));
      tbl.push_back(v(1, 0,0,0,0, 0,1,16'h3333,  1,1,0,0, A0,  1,0,0));
      // orphan: response with the FIFO drained
      tbl.push_back(v(1, 0,0,0,0, 0,1,16'hDEAD,  1,1,0,0, A0,  0,0,0));
      tbl.push_back(v(1, 0,0,0,0, 0,0,16'h0,     1,1,0,0, A0,  0,0,1));

      foreach (tbl[i])
         apply("tbl", i, tbl[i]);

      // reset for one clock in the middle of HOLD0
      apply("rst", 0, v(1, 0,1,0,0, 1,0,16'h0, 1,1,0,1, A0,  0,0,1));
      apply("rst", 1, v(0, 0,1,0,0, 1,0,16'h0, 1,1,0,0, A0,  0,0,1));
      apply("rst", 2, v(1, 0,0,0,1, 0,0,16'h0, 1,0,0,1, M1A, 0,0,0));

      // single master read: two stall cycles, data three cycles after acceptance
      apply("rd1", 0, v(1, 0,0,1,0, 1,0,16'h0,    1,1,1,0, M1A, 0,0,0));
      apply("rd1", 1, v(1, 0,0,1,0, 1,0,16'h0,    1,1,1,0, M1A, 0,0,0));
      apply("rd1", 2, v(1, 0,0,1,0, 0,0,16'h0,    1,0,1,0, M1A, 0,0,0));
      apply("rd1", 3, v(1, 0,0,0,0, 0,0,16'h0,    1,1,0,0, A0,  0,0,0));
      apply("rd1", 4, v(1, 0,0,0,0, 0,0,16'h0,    1,1,0,0, A0,  0,0,0));
      apply("rd1", 5, v(1, 0,0,0,0, 0,1,16'hBEEF, 1,1,0,0, A0,  0,1,0));
      apply("rd1", 6, v(1, 0,0,0,0, 0,0,16'h0,    1,1,0,0, A0,  0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
